// File: rtl/uart_pkg.sv
// Shared definitions for the board serial link receiver and transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_receive_if.sv
// Serial line plus received-byte outputs of the UART receiver.
interface uart_receive_if;
    import uart_pkg::*;

    logic                 rx_wire_in;
    logic                 new_data_out;
    logic [DATA_BITS-1:0] data_byte_out;
    logic                 framing_error_out;

    modport master (
        input  rx_wire_in,
        output new_data_out,
        output data_byte_out,
        output framing_error_out
    );

    modport slave (
        output rx_wire_in,
        input  new_data_out,
        input  data_byte_out,
        input  framing_error_out
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter; wraps to zero after reaching P-1 and flags that cycle.
module uart_bit_timer #(
    parameter int P = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 clear,
    input  logic                 enable,
    output logic [$clog2(P)-1:0] count,
    output logic                 terminal
);

    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    assign terminal = (count == LAST);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronizes the line, samples bit centres, reports
// each framed byte or a framing error as a one-cycle pulse.
module uart_receive
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600
) (
    input  logic    clk_in,
    input  logic    rst_in,
    uart_receive_if.master bus
);

    localparam int P    = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF = P / 2;
    localparam int CW   = $clog2(P);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;

    uart_state_t state;
    uart_state_t state_next;

    logic [IW-1:0]        bit_idx;
    logic [IW-1:0]        bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] data_byte;
    logic [DATA_BITS-1:0] data_byte_next;
    logic                 new_data;
    logic                 new_data_next;
    logic                 framing_error;
    logic                 framing_error_next;

    logic          timer_clear;
    logic          timer_enable;
    logic [CW-1:0] count;
    logic          terminal;

    uart_bit_timer #(.P(P)) bit_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (timer_clear),
        .enable   (timer_enable),
        .count    (count),
        .terminal (terminal)
    );

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx_wire_in;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            bit_idx       <= '0;
            shift_reg     <= '0;
            data_byte     <= '0;
            new_data      <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_next;
            bit_idx       <= bit_idx_next;
            shift_reg     <= shift_next;
            data_byte     <= data_byte_next;
            new_data      <= new_data_next;
            framing_error <= framing_error_next;
        end
    end

    always_comb begin
        state_next         = state;
        bit_idx_next       = bit_idx;
        shift_next         = shift_reg;
        data_byte_next     = data_byte;
        new_data_next      = 1'b0;
        framing_error_next = 1'b0;
        timer_clear        = 1'b0;
        timer_enable       = 1'b0;

        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (!rx_sync) begin
                    state_next = START;
                end
            end

            // A start bit that is gone by mid-bit was only a glitch.
            START: begin
                if (count == HALF_LAST) begin
                    timer_clear = 1'b1;
                    if (!rx_sync) begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_enable = 1'b1;
                end
            end

            DATA: begin
                timer_enable = 1'b1;
                if (terminal) begin
                    shift_next[bit_idx] = rx_sync;
                    if (bit_idx == LAST_BIT) begin
                        state_next   = STOP;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end

            STOP: begin
                timer_enable = 1'b1;
                if (terminal) begin
                    if (rx_sync) begin
                        data_byte_next = shift_reg;
                        new_data_next  = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        framing_error_next = 1'b1;
                        state_next         = WAIT_HIGH;
                    end
                end
            end

            // A held-low line (break) must not be parsed as a stream of frames.
            WAIT_HIGH: begin
                timer_clear = 1'b1;
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.new_data_out      = new_data;
    assign bus.data_byte_out     = data_byte;
    assign bus.framing_error_out = framing_error;

endmodule
